rr_grant_fsm: RTL and testbench

Round-robin arbiter that shares one single-user resource, such as the Mealy FSM datapath, among N requesters. It is written as a classic three-process FSM with registered state, combinational next-state logic and mixed registered/Mealy outputs. It bounds each tenure with a hold limit, preempts only when another requester is waiting, and inserts one dead cycle between owners for resource turnaround.

---
 rtl/rr_grant_fsm.sv | 127 ++++++++++++
 tb/tb_rr_grant_fsm.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rr_grant_fsm.sv
// Round-robin arbiter granting one shared resource to N requesters, with a
// bounded tenure under contention and a one-cycle turnaround gap between owners.
module rr_grant_fsm #(
  parameter int unsigned N        = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic [ID_W-1:0] owner,
  output logic            expire
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RECOVER = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]  LastId   = ID_W'(N - 1);

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [ID_W-1:0] owner_q, owner_d;

  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            any_req;
  logic            owner_req;
  logic            others_req;
  logic            hold_last;
  logic [ID_W-1:0] ptr_next;

  // First requester found scanning upward from ptr, wrapping modulo N.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      idx = ID_W'((int'(ptr_q) + k) % int'(N));
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign any_req    = |req;
  assign owner_req  = req[owner_q];
  assign others_req = |(req & ~grant_q);
  assign hold_last  = (hold_q == HoldLast);
  assign ptr_next   = (owner_q == LastId) ? '0 : owner_q + ID_W'(1);

  // Preemption pulse: only fires while the owner still wants the resource.
  assign expire = (state_q == ST_GRANT) & owner_req & hold_last & others_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE, ST_RECOVER: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        if (any_req) begin
          state_d = ST_GRANT;
          owner_d = win;
          grant_d = N'(1) << win;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        // Release takes precedence over expiry; both rotate priority past the owner.
        if (!owner_req || expire) begin
          state_d = ST_RECOVER;
          ptr_d   = ptr_next;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (!hold_last) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Bench for rr_grant_fsm: directed scenarios plus random request traffic,
// all compared against a tenure-counting reference model.
module tb_rr_grant_fsm;

  localparam int unsigned N        = 4;
  localparam int unsigned ID_W     = 2;
  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned CNT_W    = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    grant;
  logic            busy;
  logic [ID_W-1:0] owner;
  logic            expire;

  int checks = 0;
  int errors = 0;

  // Reference model: whether the resource is owned, by whom, for how long.
  bit m_owned  = 1'b0;
  int m_owner  = 0;
  int m_ptr    = 0;
  int m_tenure = 0;

  rr_grant_fsm #(.N(N), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .grant(grant), .busy(busy), .owner(owner), .expire(expire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare current outputs with the model, then advance it over the next edge.
  task automatic eval();
    logic [N-1:0] exp_g;
    logic         exp_x;
    exp_g = m_owned ? (N'(1) << m_owner) : '0;
    exp_x = m_owned && req[ID_W'(m_owner)] && (m_tenure >= int'(MAX_HOLD))
            && ((req & ~exp_g) != '0);
    chk("grant", 32'(grant), 32'(exp_g));
    chk("busy", 32'(busy), 32'(m_owned));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("expire", 32'(expire), 32'(exp_x));
    if (m_owned) begin
      if (!req[ID_W'(m_owner)] || exp_x) begin
        m_owned = 1'b0;
        m_ptr   = (m_owner + 1) % int'(N);
      end else begin
        m_tenure++;
      end
    end else if (req != '0) begin
      for (int k = 0; k < int'(N); k++) begin
        if (!m_owned && req[ID_W'((m_ptr + k) % int'(N))]) begin
          m_owned  = 1'b1;
          m_owner  = (m_ptr + k) % int'(N);
          m_tenure = 1;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    #1;
    eval();
  endtask

  // Asynchronous reset from wherever we are; released at a negedge with req=r.
  task automatic do_reset(input logic [N-1:0] r);
    reset_n = 1'b0;
    req     = '0;
    #1;
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_expire", 32'(expire), 32'(0));
    m_owned = 1'b0; m_owner = 0; m_ptr = 0; m_tenure = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    req     = r;
    #1;
    eval();
  endtask

  initial begin
    logic [N-1:0] r;

    // Sole requester keeps the grant well past MAX_HOLD.
    do_reset(4'b0100);
    for (int c = 1; c <= 20; c++) begin
      step(4'b0100);
      chk("single_grant", 32'(grant), 32'(4'b0100));
      chk("single_expire", 32'(expire), 32'(0));
    end
    step(4'b0000);
    chk("single_last", 32'(grant), 32'(4'b0100));
    step(4'b0000);
    chk("single_drop", 32'(grant), 32'(0));
    step(4'b0000);

    // Full contention: 0,1,2,3,0 with MAX_HOLD tenures and one-cycle gaps.
    do_reset(4'b1111);
    for (int c = 1; c <= 40; c++) begin
      step(4'b1111);
      if (c == 8)  chk("all_expire8", 32'(expire), 32'(1));
      if (c == 7)  chk("all_noexp7", 32'(expire), 32'(0));
      if (c == 9)  chk("all_gap9", 32'(grant), 32'(0));
      if (c == 10) chk("all_g1", 32'(grant), 32'(4'b0010));
      if (c == 19) chk("all_g2", 32'(grant), 32'(4'b0100));
      if (c == 28) chk("all_g3", 32'(grant), 32'(4'b1000));
      if (c == 37) chk("all_g0", 32'(grant), 32'(4'b0001));
    end

    // Early release by requester 0 in cycle 3.
    do_reset(4'b0011);
    step(4'b0011); step(4'b0011);
    step(4'b0010); chk("early_c3", 32'(grant), 32'(4'b0001));
    step(4'b0010); chk("early_gap", 32'(grant), 32'(0));
    step(4'b0010); chk("early_next", 32'(grant), 32'(4'b0010));

    // Release in the same cycle as hold expiry counts as a release.
    do_reset(4'b0011);
    for (int c = 1; c <= 7; c++) step(4'b0011);
    step(4'b0010); chk("coinc_noexp", 32'(expire), 32'(0));
    chk("coinc_c8", 32'(grant), 32'(4'b0001));
    step(4'b0010); chk("coinc_gap", 32'(grant), 32'(0));
    step(4'b0010); chk("coinc_next", 32'(grant), 32'(4'b0010));

    // Pointer wraps from 3 back to 0.
    do_reset(4'b1000);
    step(4'b1000); chk("wrap_own3", 32'(grant), 32'(4'b1000));
    step(4'b0000);
    step(4'b1001); chk("wrap_gap", 32'(grant), 32'(0));
    step(4'b1001); chk("wrap_g0", 32'(grant), 32'(4'b0001));
    step(4'b1000);
    step(4'b1000); chk("wrap_gap2", 32'(grant), 32'(0));
    step(4'b1000); chk("wrap_g3", 32'(grant), 32'(4'b1000));

    // Reset mid-tenure while requester 1 owns the resource.
    do_reset(4'b0010);
    for (int c = 1; c <= 4; c++) step(4'b0010);
    chk("midrst_pre_owner", 32'(owner), 32'(1));
    #2;
    do_reset(4'b1111);
    step(4'b1111); chk("midrst_first", 32'(grant), 32'(4'b0001));

    // Random traffic with sticky requests and one reset mid-run.
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < int'(N); b++)
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      if (i == 300) begin
        #2;
        do_reset(r);
      end else begin
        step(r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
